tt_sweep_ctrl: RTL and testbench
================================

// Module: tt_sweep_ctrl
// PURPOSE
//  Sequencer that exhaustively exercises a NIN-input combinational function block (majority-network classifier).
//  Drives every input vector 0..2^NIN-1 onto x_o and captures f_i into a truth-table register.
//  Compares the captured table against EXPECTED and reports match plus the first mismatching index.
//  Sits between the test/config host and one instance of a classification function.
// PARAMETERS
//  NIN       7                                    number of function inputs (2..8)
//  EXPECTED  128'hfee8eaa8eaa8e8a8eae8eaa8eaa8e880  golden truth table; bit i = f(x=i), x0 = LSB of i
// PORTS
//  clk           in   1         single clock, rising edge
//  rst           in   1         synchronous, active-high reset
//  start         in   1         request a sweep; honoured only in IDLE
//  abort         in   1         cancel a running sweep
//  busy          out  1         high from the cycle after start accepted until DONE
//  done          out  1         one-cycle pulse; table, match and mismatch fields valid
//  x_o           out  NIN       input vector driven to the function block
//  f_i           in   1         function output, combinational from x_o
//  tt_o          out  2^NIN     captured truth table
//  match         out  1         tt_o == EXPECTED; updated at done
//  mismatch_vld  out  1         at least one index differed in the last sweep
//  mismatch_idx  out  NIN       lowest differing index; 0 when mismatch_vld=0
// BEHAVIOUR
//  Reset: all outputs 0, x_o=0, state IDLE, idx=0.
//  States:
//   - IDLE -> SWEEP on start. On that same edge: clear tt_o, match and mismatch_*; set idx=0.
//   - SWEEP, each cycle:
//     - x_o=idx.
//     - Write f_i into tt_o[idx].
//     - If f_i!=EXPECTED[idx] and !mismatch_vld: set mismatch_vld=1, mismatch_idx=idx.
//     - idx++.
//     - When idx==2^NIN-1 is written -> DONE.
//   - DONE: done=1 and match registered for exactly one cycle, then IDLE; busy drops with done.
//  Latency: start sampled at edge k -> busy at k+1 -> done pulse in cycle k+1+2^NIN (129 for NIN=7).
//  Counter is NIN+1 bits wide so terminal detection has no wrap ambiguity; x_o never exceeds 2^NIN-1.
//  abort in SWEEP:
//   - -> IDLE next edge; done not pulsed; match stays 0.
//   - tt_o and mismatch_* keep their partial contents.
//  abort in IDLE/DONE: ignored. abort and start in the same IDLE cycle: start wins.
//  start while busy or in DONE: ignored, not queued.
//  rst mid-sweep: immediate return to reset values; no done.
//  Bit ordering: tt_o[i] corresponds to x_o=i, i.e. x0 = bit 0 and x6 = bit 6 of the index.
// CONFIGURATION
//  TT_PIPE_EN defined:
//   - f_i is registered once before capture.
//   - Capture uses idx delayed by 1, written to tt_o[idx_d].
//   - Extra DRAIN state after the last x_o captures the final sample.
//   - done moves to cycle k+2+2^NIN.
//   - x_o holds the last vector during DRAIN.
//   - abort also discards the in-flight sample.
//  TT_PIPE_EN undefined: purely combinational capture, timing as above.
// TESTING
//  1. Golden model (majority network, NIN=7), start pulse at cycle 0
//     -> done at cycle 129; tt_o=EXPECTED; match=1; mismatch_vld=0.
//  2. f_i forced constant 0
//     -> match=0, mismatch_vld=1, mismatch_idx=7 (lowest set bit of 0x...880); tt_o=0.
//  3. Golden model with f_i inverted at x=0x55 only
//     -> mismatch_idx=0x55, tt_o=EXPECTED^(1<<85), match=0.
//  4. abort at x_o=40, then start again
//     -> no done after the abort; second sweep completes with match=1 and busy low for at least one IDLE cycle between.
//  5. rst asserted at x_o=100
//     -> next cycle all outputs 0.
//     -> start pulse during busy of a later sweep has no effect on its timing.
//  6. TT_PIPE_EN defined, golden model
//     -> done at cycle 130; tt_o=EXPECTED; bit 127 captured correctly.

Source files
------------

// File: rtl/tt_sweep_if.sv
// Host-side handshake bundle for tt_sweep_ctrl.
//  master : host/test controller (drives start/abort, observes status and results)
//  slave  : sweep controller (drives busy/done and the captured results)
// Signals:
//  start        request a sweep
//  abort        cancel a running sweep
//  busy         sweep in progress
//  done         one-cycle completion pulse
//  tt_o         captured truth table, 2^NIN bits
//  match        captured table equals the golden table
//  mismatch_vld at least one index differed
//  mismatch_idx lowest differing index
interface tt_sweep_if #(
  parameter int unsigned NIN = 7
);
  logic                   start;
  logic                   abort;
  logic                   busy;
  logic                   done;
  logic [(1 << NIN)-1:0]  tt_o;
  logic                   match;
  logic                   mismatch_vld;
  logic [NIN-1:0]         mismatch_idx;

  modport master (
    output start, abort,
    input  busy, done, tt_o, match, mismatch_vld, mismatch_idx
  );

  modport slave (
    input  start, abort,
    output busy, done, tt_o, match, mismatch_vld, mismatch_idx
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive truth-table sweeper for a NIN-input combinational function block.
// Drives every vector 0..2^NIN-1 on x_o, captures f_i into tt_o and compares against EXPECTED,
// reporting a match flag and the lowest mismatching index.
// Ports:
//  clk   rising-edge clock
//  rst   synchronous active-high reset
//  host  tt_sweep_if.slave: start/abort in; busy/done/tt_o/match/mismatch_* out
//  x_o   vector driven to the function block
//  f_i   function output (combinational from x_o)
// Configuration macro: TT_PIPE_EN -- registers f_i once before capture and adds a DRAIN state,
// moving done one cycle later. Undefined (default): combinational capture.
module tt_sweep_ctrl #(
  parameter int unsigned          NIN      = 7,
  parameter logic [(1<<NIN)-1:0]  EXPECTED = 128'hfee8eaa8eaa8e8a8eae8eaa8eaa8e880
) (
  input  logic           clk,
  input  logic           rst,
  tt_sweep_if.slave      host,
  output logic [NIN-1:0] x_o,
  input  logic           f_i
);

  localparam int unsigned Size = 1 << NIN;
  localparam logic [NIN:0] IdxLast = {1'b0, {NIN{1'b1}}};

  typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [NIN:0]    idx_q, idx_d;
  logic [Size-1:0] tt_q, tt_d;
  logic            match_q, match_d;
  logic            mm_vld_q, mm_vld_d;
  logic [NIN-1:0]  mm_idx_q, mm_idx_d;

  logic            cap_en;
  logic [NIN-1:0]  cap_idx;
  logic            cap_bit;

`ifdef TT_PIPE_EN
  // One-deep capture pipeline: sample of f_i plus the index it belongs to.
  logic            f_q;
  logic [NIN-1:0]  idx_p_q;
  logic            vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q     <= 1'b0;
      idx_p_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      f_q     <= f_i;
      idx_p_q <= idx_q[NIN-1:0];
      vld_q   <= (state_q == StSweep) && !host.abort;
    end
  end

  // An abort discards the sample still sitting in the pipeline.
  always_comb begin
    cap_en  = vld_q && !host.abort;
    cap_idx = idx_p_q;
    cap_bit = f_q;
  end
`else
  always_comb begin
    cap_en  = (state_q == StSweep) && !host.abort;
    cap_idx = idx_q[NIN-1:0];
    cap_bit = f_i;
  end
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tt_d     = tt_q;
    match_d  = match_q;
    mm_vld_d = mm_vld_q;
    mm_idx_d = mm_idx_q;

    if (cap_en) begin
      tt_d[cap_idx] = cap_bit;
      // Only the first (lowest) differing index is recorded.
      if ((cap_bit != EXPECTED[cap_idx]) && !mm_vld_q) begin
        mm_vld_d = 1'b1;
        mm_idx_d = cap_idx;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (host.start) begin
          state_d  = StSweep;
          idx_d    = '0;
          tt_d     = '0;
          match_d  = 1'b0;
          mm_vld_d = 1'b0;
          mm_idx_d = '0;
        end
      end
      StSweep: begin
        if (host.abort) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (idx_q == IdxLast) begin
          // idx holds at the last vector so x_o never leaves the valid range.
`ifdef TT_PIPE_EN
          state_d = StDrain;
`else
          state_d = StDone;
          match_d = !mm_vld_d;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDrain: begin
        if (host.abort) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          state_d = StDone;
          match_d = !mm_vld_d;
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      tt_q     <= '0;
      match_q  <= 1'b0;
      mm_vld_q <= 1'b0;
      mm_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tt_q     <= tt_d;
      match_q  <= match_d;
      mm_vld_q <= mm_vld_d;
      mm_idx_q <= mm_idx_d;
    end
  end

  assign x_o               = idx_q[NIN-1:0];
  assign host.busy         = (state_q == StSweep) || (state_q == StDrain);
  assign host.done         = (state_q == StDone);
  assign host.tt_o         = tt_q;
  assign host.match        = match_q;
  assign host.mismatch_vld = mm_vld_q;
  assign host.mismatch_idx = mm_idx_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench for tt_sweep_ctrl (NIN=7). The function block is modelled as a lookup
// table fn_tbl indexed by x_o; expected results come from a table-level reference model.
module tb_tt_sweep_ctrl;
  localparam int unsigned NIN  = 7;
  localparam int unsigned Size = 128;
  localparam logic [127:0] Exp = 128'hfee8eaa8eaa8e8a8eae8eaa8eaa8e880;
`ifdef TT_PIPE_EN
  localparam int ExpLat = Size + 2;
`else
  localparam int ExpLat = Size + 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NIN-1:0] x;
  logic           f;
  logic [127:0]   fn_tbl;
  int             vectors = 0;
  int             miscompares = 0;

  tt_sweep_if #(.NIN(NIN)) bus ();

  tt_sweep_ctrl #(.NIN(NIN), .EXPECTED(Exp)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus),
    .x_o  (x),
    .f_i  (f)
  );

  always #5 clk = ~clk;

  always_comb f = fn_tbl[x];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lowest differing index and match flag, straight from the table definition.
  function automatic void ref_model(input logic [127:0] tbl, output logic m, output logic v,
                                    output logic [6:0] idx);
    m   = (tbl == Exp);
    v   = 1'b0;
    idx = '0;
    for (int i = int'(Size) - 1; i >= 0; i--) begin
      if (tbl[i] !== Exp[i]) begin
        v   = 1'b1;
        idx = 7'(i);
      end
    end
  endfunction

  // Pulse start, then run to done (bounded). spur_at re-pulses start mid-sweep.
  task automatic sweep(input int spur_at, output int lat);
    int cyc;
    int xbad;
    logic busy1;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    cyc   = 1;
    xbad  = 0;
    busy1 = bus.busy;
    while (bus.done !== 1'b1 && cyc < 400) begin
      if (cyc <= int'(Size) && x !== 7'(cyc - 1)) xbad++;
      bus.start = (cyc == spur_at);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    lat = cyc;
    chk("busy_after_start", 128'(busy1), 128'(1));
    chk("x_sequence_errors", 128'(xbad), 128'(0));
  endtask

  // Start a sweep and stop once x_o reaches target (bounded).
  task automatic run_to(input logic [6:0] target);
    int n;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    n = 0;
    while (x !== target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_x", 128'(x), 128'(target));
  endtask

  initial begin
    int           lat;
    int           dones;
    logic         m, v;
    logic [6:0]   ri;
    logic [127:0] tbl;
    logic [127:0] one;

    one       = 128'd1;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    fn_tbl    = Exp;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    chk("rst_x", 128'(x), 128'(0));
    chk("rst_tt", bus.tt_o, 128'(0));
    chk("rst_mm_vld", 128'(bus.mismatch_vld), 128'(0));
    rst = 1'b0;

    // Golden function.
    sweep(0, lat);
    chk("gold_lat", 128'(lat), 128'(ExpLat));
    chk("gold_tt", bus.tt_o, Exp);
    chk("gold_match", 128'(bus.match), 128'(1));
    chk("gold_mm_vld", 128'(bus.mismatch_vld), 128'(0));
    chk("gold_mm_idx", 128'(bus.mismatch_idx), 128'(0));
    chk("gold_busy_at_done", 128'(bus.busy), 128'(0));
    // start during DONE is ignored; done lasts one cycle.
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    chk("done_one_cycle", 128'(bus.done), 128'(0));
    chk("start_in_done_ignored", 128'(bus.busy), 128'(0));
    @(negedge clk);

    // Constant-zero function.
    fn_tbl = '0;
    sweep(0, lat);
    chk("zero_lat", 128'(lat), 128'(ExpLat));
    chk("zero_tt", bus.tt_o, 128'(0));
    chk("zero_match", 128'(bus.match), 128'(0));
    chk("zero_mm_vld", 128'(bus.mismatch_vld), 128'(1));
    chk("zero_mm_idx", 128'(bus.mismatch_idx), 128'(7));

    // Single flipped entry at 0x55.
    fn_tbl = Exp ^ (one << 85);
    sweep(0, lat);
    chk("flip_tt", bus.tt_o, Exp ^ (one << 85));
    chk("flip_match", 128'(bus.match), 128'(0));
    chk("flip_mm_vld", 128'(bus.mismatch_vld), 128'(1));
    chk("flip_mm_idx", 128'(bus.mismatch_idx), 128'(8'h55));

    // Abort at x=40, then a clean sweep.
    fn_tbl = Exp;
    run_to(7'd40);
    bus.abort = 1'b1;
    @(negedge clk) bus.abort = 1'b0;
    chk("abort_busy", 128'(bus.busy), 128'(0));
    dones = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("abort_no_done", 128'(dones), 128'(0));
    chk("abort_match", 128'(bus.match), 128'(0));
    sweep(0, lat);
    chk("post_abort_lat", 128'(lat), 128'(ExpLat));
    chk("post_abort_match", 128'(bus.match), 128'(1));

    // Reset at x=100.
    @(negedge clk);
    run_to(7'd100);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("mrst_busy", 128'(bus.busy), 128'(0));
    chk("mrst_x", 128'(x), 128'(0));
    chk("mrst_tt", bus.tt_o, 128'(0));
    chk("mrst_match", 128'(bus.match), 128'(0));
    chk("mrst_mm_vld", 128'(bus.mismatch_vld), 128'(0));
    chk("mrst_mm_idx", 128'(bus.mismatch_idx), 128'(0));
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("mrst_no_done", 128'(dones), 128'(0));

    // Spurious start while busy must not disturb timing.
    sweep(50, lat);
    chk("spur_lat", 128'(lat), 128'(ExpLat));
    chk("spur_match", 128'(bus.match), 128'(1));
    @(negedge clk);

    // Randomized function tables against the reference model.
    for (int r = 0; r < 6; r++) begin
      tbl = Exp;
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        tbl[$urandom_range(0, 127)] ^= 1'b1;
      end
      if (r == 5) tbl = {$urandom, $urandom, $urandom, $urandom};
      fn_tbl = tbl;
      ref_model(tbl, m, v, ri);
      sweep(int'($urandom_range(2, 120)), lat);
      chk("rnd_lat", 128'(lat), 128'(ExpLat));
      chk("rnd_tt", bus.tt_o, tbl);
      chk("rnd_match", 128'(bus.match), 128'(m));
      chk("rnd_mm_vld", 128'(bus.mismatch_vld), 128'(v));
      chk("rnd_mm_idx", 128'(bus.mismatch_idx), 128'(ri));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
